status_hud: RTL and testbench

- Parametrised successor to the fixed-position status-bar region detector.
- Owns game status state: a saturating life counter, a BCD score counter, an invulnerability/blink state machine and game-over.
- Produces per-pixel HUD hit flags and sprite-ROM addresses for the colour mapper.
- Sits between game logic (event pulses) and the VGA colour mapper (DrawX/DrawY).

---
 rtl/status_hud.sv | 210 +++++++++++++++++++++
 tb/tb_status_hud.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/status_hud.sv
// status_hud: game status state (lives, BCD score, invulnerability/blink FSM) plus per-pixel HUD decode.
// Optional macro HUD_EXTRA_LIFE_EN: award a life on every score carry into the thousands digit.
module status_hud #(
   parameter int X_POS         = 10,
   parameter int Y_POS         = 10,
   parameter int ICON_W        = 12,
   parameter int ICON_H        = 12,
   parameter int ICON_GAP      = 4,
   parameter int MAX_LIVES     = 5,
   parameter int INIT_LIVES    = 3,
   parameter int SCORE_DIGITS  = 4,
   parameter int DIGIT_W       = 8,
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic                              frame_clk,
   input  logic [9:0]                        DrawX,
   input  logic [9:0]                        DrawY,
   input  logic                              hit,
   input  logic                              life_up,
   input  logic                              score_inc,
   input  logic                              restart,
   output logic [$clog2(MAX_LIVES+1)-1:0]    lives,
   output logic [4*SCORE_DIGITS-1:0]         score_bcd,
   output logic                              game_over,
   output logic                              invuln,
   output logic                              is_hud,
   output logic                              is_life_icon,
   output logic                              is_score_digit,
   output logic [9:0]                        icon_x_addr,
   output logic [9:0]                        icon_y_addr,
   output logic [9:0]                        digit_x_addr,
   output logic [3:0]                        digit_value
);
   localparam int LW     = $clog2(MAX_LIVES + 1);
   localparam int SW     = 4 * SCORE_DIGITS;
   localparam int CW     = $clog2(INVULN_FRAMES + 1);
   localparam int HALF   = BLINK_FRAMES / 2;
   localparam int BW     = $clog2(HALF + 1);
   localparam int SLOT_W = ICON_W + ICON_GAP;
   localparam int SC_X   = X_POS + MAX_LIVES * SLOT_W;
   localparam int HUD_R  = SC_X + SCORE_DIGITS * DIGIT_W;
   localparam logic [SW-1:0] ALL9 = {SCORE_DIGITS{4'h9}};

   if (INIT_LIVES > MAX_LIVES) begin : g_bad_init
      $error("INIT_LIVES must not exceed MAX_LIVES");
   end
`ifdef HUD_EXTRA_LIFE_EN
   if (SCORE_DIGITS < 4) begin : g_bad_digits
      $error("HUD_EXTRA_LIFE_EN needs SCORE_DIGITS >= 4");
   end
`endif

   typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

   state_t         state_q, state_nxt;
   logic [LW-1:0]  lives_q, lives_nxt;
   logic [SW-1:0]  score_q, score_nxt;
   logic [CW-1:0]  cnt_q, cnt_nxt;
   logic [BW-1:0]  bcnt_q, bcnt_nxt;
   logic           blink_q, blink_nxt;
   logic [2:0]     fs;
   logic           frame_tick;
   logic           bonus;

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      logic          c;
      r = s;
      c = 1'b1;
      if (s == ALL9) return s;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         if (c) begin
            if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
            else begin
               r[4*d +: 4] = r[4*d +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [LW-1:0] lives_inc(input logic [LW-1:0] l);
      return (l >= LW'(MAX_LIVES)) ? l : l + LW'(1);
   endfunction

   // fs[1:0] synchronise frame_clk; fs[2] delays it for the rising-edge detect
   assign frame_tick = fs[1] & ~fs[2];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fs      <= '0;
         state_q <= ALIVE;
         lives_q <= LW'(INIT_LIVES);
         score_q <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         fs      <= {fs[1:0], frame_clk};
         state_q <= state_nxt;
         lives_q <= lives_nxt;
         score_q <= score_nxt;
         cnt_q   <= cnt_nxt;
         bcnt_q  <= bcnt_nxt;
         blink_q <= blink_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      lives_nxt = lives_q;
      score_nxt = score_q;
      cnt_nxt   = cnt_q;
      bcnt_nxt  = bcnt_q;
      blink_nxt = blink_q;
`ifdef HUD_EXTRA_LIFE_EN
      bonus = score_inc && (score_q[11:0] == 12'h999) && (score_q != ALL9);
`else
      bonus = 1'b0;
`endif
      if (restart) begin
         state_nxt = ALIVE;
         lives_nxt = LW'(INIT_LIVES);
         score_nxt = '0;
         cnt_nxt   = '0;
         bcnt_nxt  = '0;
         blink_nxt = 1'b0;
      end else if (state_q != DEAD) begin
         if (score_inc) score_nxt = bcd_inc(score_q);
         if (hit && state_q == ALIVE) begin
            if (lives_q > LW'(1)) begin
               lives_nxt = lives_q - LW'(1);
               state_nxt = INVULN;
               cnt_nxt   = CW'(INVULN_FRAMES);
               bcnt_nxt  = '0;
               blink_nxt = 1'b0;
            end else begin
               lives_nxt = '0;
               state_nxt = DEAD;
            end
         end else begin
            if (life_up) lives_nxt = lives_inc(lives_nxt);
            if (bonus)   lives_nxt = lives_inc(lives_nxt);
            if (state_q == INVULN && frame_tick) begin
               if (cnt_q <= CW'(1)) begin
                  state_nxt = ALIVE;
                  cnt_nxt   = '0;
                  bcnt_nxt  = '0;
                  blink_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt_q - CW'(1);
                  if (bcnt_q == BW'(HALF - 1)) begin
                     bcnt_nxt  = '0;
                     blink_nxt = ~blink_q;
                  end else begin
                     bcnt_nxt = bcnt_q + BW'(1);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      game_over = (state_q == DEAD);
      invuln    = (state_q == INVULN);
   end

   assign lives     = lives_q;
   assign score_bcd = score_q;

   // Pixel decode: widened to 11 bits so region ends past 1023 still compare correctly
   always_comb begin
      logic [10:0] x, y;
      logic        in_rows;
      x = {1'b0, DrawX};
      y = {1'b0, DrawY};
      is_hud         = 1'b0;
      is_life_icon   = 1'b0;
      is_score_digit = 1'b0;
      icon_x_addr    = '0;
      icon_y_addr    = '0;
      digit_x_addr   = '0;
      digit_value    = '0;
      in_rows = (y >= 11'(Y_POS)) && (y < 11'(Y_POS + ICON_H));
      if (in_rows) begin
         is_hud = (x >= 11'(X_POS)) && (x < 11'(HUD_R));
         for (int i = 0; i < MAX_LIVES; i++) begin
            if ((x >= 11'(X_POS + i*SLOT_W)) && (x < 11'(X_POS + i*SLOT_W + ICON_W)) &&
                (LW'(i) < lives_q) && !(invuln && blink_q)) begin
               is_life_icon = 1'b1;
               icon_x_addr  = 10'(x - 11'(X_POS + i*SLOT_W));
               icon_y_addr  = 10'(y - 11'(Y_POS));
            end
         end
         for (int j = 0; j < SCORE_DIGITS; j++) begin
            if ((x >= 11'(SC_X + j*DIGIT_W)) && (x < 11'(SC_X + (j+1)*DIGIT_W))) begin
               is_score_digit = 1'b1;
               digit_x_addr   = 10'(x - 11'(SC_X + j*DIGIT_W));
               icon_y_addr    = 10'(y - 11'(Y_POS));
               digit_value    = score_q[4*(SCORE_DIGITS-1-j) +: 4];
            end
         end
      end
   end
endmodule

// File: tb/tb_status_hud.sv
// Directed bench for status_hud with default parameters.
module tb_status_hud;
   logic        Clk = 1'b0;
   logic        Reset, frame_clk, hit, life_up, score_inc, restart;
   logic [9:0]  DrawX, DrawY;
   logic [2:0]  lives;
   logic [15:0] score_bcd;
   logic        game_over, invuln, is_hud, is_life_icon, is_score_digit;
   logic [9:0]  icon_x_addr, icon_y_addr, digit_x_addr;
   logic [3:0]  digit_value;
   int          total = 0;
   int          bad = 0;

   status_hud dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
      .hit(hit), .life_up(life_up), .score_inc(score_inc), .restart(restart),
      .lives(lives), .score_bcd(score_bcd), .game_over(game_over), .invuln(invuln),
      .is_hud(is_hud), .is_life_icon(is_life_icon), .is_score_digit(is_score_digit),
      .icon_x_addr(icon_x_addr), .icon_y_addr(icon_y_addr), .digit_x_addr(digit_x_addr),
      .digit_value(digit_value)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int which);
      @(negedge Clk);
      case (which)
         0: hit = 1'b1;
         1: life_up = 1'b1;
         2: score_inc = 1'b1;
         3: restart = 1'b1;
         default: begin hit = 1'b1; life_up = 1'b1; end
      endcase
      @(negedge Clk);
      hit = 1'b0; life_up = 1'b0; score_inc = 1'b0; restart = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge Clk); frame_clk = 1'b1;
         repeat (3) @(negedge Clk);
         frame_clk = 1'b0;
         repeat (3) @(negedge Clk);
      end
   endtask

   task automatic hold_score(input int n);
      @(negedge Clk); score_inc = 1'b1;
      repeat (n) @(negedge Clk);
      score_inc = 1'b0;
   endtask

   task automatic pix(input int px, input int py);
      DrawX = 10'(px);
      DrawY = 10'(py);
      #1;
   endtask

   initial begin
      Reset = 1'b0; frame_clk = 1'b0; hit = 1'b0; life_up = 1'b0; score_inc = 1'b0;
      restart = 1'b0; DrawX = 10'd10; DrawY = 10'd10;
      repeat (3) @(negedge Clk);
      check("rst_lives", lives, 3);
      check("rst_score", score_bcd, 16'h0000);
      check("rst_game_over", game_over, 0);
      check("rst_invuln", invuln, 0);
      Reset = 1'b1;
      @(negedge Clk);
      pix(10, 10);
      check("rst_icon", is_life_icon, 1);
      check("rst_icon_x", icon_x_addr, 0);
      check("rst_icon_y", icon_y_addr, 0);

      // hit, invulnerability and blink
      pulse(0);
      check("hit1_lives", lives, 2);
      check("hit1_invuln", invuln, 1);
      frames(3);
      check("blink_f3_shown", is_life_icon, 1);
      frames(1);
      check("blink_f4_hidden", is_life_icon, 0);
      frames(1);
      pulse(0);
      check("hit_ignored", lives, 2);
      frames(3);
      check("blink_f8_shown", is_life_icon, 1);
      frames(4);
      check("blink_f12_hidden", is_life_icon, 0);
      frames(47);
      check("invuln_f59", invuln, 1);
      frames(1);
      check("invuln_f60", invuln, 0);

      // drain lives to game over
      pulse(0);
      check("hit2_lives", lives, 1);
      frames(60);
      check("hit2_done", invuln, 0);
      pulse(0);
      check("hit3_lives", lives, 0);
      check("hit3_game_over", game_over, 1);
      check("hit3_invuln", invuln, 0);
      pulse(2);
      pulse(1);
      check("dead_lives", lives, 0);
      check("dead_score", score_bcd, 16'h0000);
      check("dead_stays", game_over, 1);
      pulse(3);
      check("restart_lives", lives, 3);
      check("restart_score", score_bcd, 16'h0000);
      check("restart_game_over", game_over, 0);

      // geometry with three lives
      pix(42, 15);
      check("slot2_icon", is_life_icon, 1);
      check("slot2_x", icon_x_addr, 0);
      check("slot2_y", icon_y_addr, 5);
      pix(21, 15);
      check("slot0_last_icon", is_life_icon, 1);
      check("slot0_last_x", icon_x_addr, 11);
      pix(22, 15);
      check("gap_icon", is_life_icon, 0);
      check("gap_hud", is_hud, 1);
      pix(58, 15);
      check("slot3_icon", is_life_icon, 0);
      check("slot3_hud", is_hud, 1);
      pix(90, 15);
      check("digit0_flag", is_score_digit, 1);
      check("digit0_x", digit_x_addr, 0);
      check("digit0_val", digit_value, 0);
      pix(9, 15);
      check("left_hud", is_hud, 0);
      check("left_addr", icon_x_addr, 0);
      pix(121, 21);
      check("corner_hud", is_hud, 1);
      check("corner_digit_x", digit_x_addr, 7);
      pix(122, 15);
      check("right_hud", is_hud, 0);
      pix(42, 22);
      check("below_icon", is_life_icon, 0);
      check("below_hud", is_hud, 0);

      // BCD score carry and saturation
      hold_score(999);
      check("score_0999", score_bcd, 16'h0999);
      check("lives_pre_carry", lives, 3);
      pulse(2);
      check("score_1000", score_bcd, 16'h1000);
`ifdef HUD_EXTRA_LIFE_EN
      check("carry_bonus", lives, 4);
`else
      check("carry_no_bonus", lives, 3);
`endif
      pix(90, 10);
      check("digit0_val_1", digit_value, 1);
      pix(114, 10);
      check("digit3_val_0", digit_value, 0);
      hold_score(8999);
      check("score_9999", score_bcd, 16'h9999);
      pulse(2);
      check("score_sat", score_bcd, 16'h9999);

      // simultaneous hit and life_up, life_up in INVULN, restart in INVULN
      pulse(3);
      pulse(0);
      frames(60);
      check("pre_combo_lives", lives, 2);
      check("pre_combo_alive", invuln, 0);
      pulse(4);
      check("combo_lives", lives, 1);
      check("combo_invuln", invuln, 1);
      pulse(1);
      check("invuln_life_up", lives, 2);
      check("invuln_life_up_state", invuln, 1);
      @(negedge Clk); frame_clk = 1'b1;
      pulse(3);
      check("restart_inv_invuln", invuln, 0);
      check("restart_inv_lives", lives, 3);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      check("restart_inv_stays", invuln, 0);

      // held-high frame_clk gives a single tick, then async reset mid-INVULN
      pulse(0);
      frames(3);
      @(negedge Clk); frame_clk = 1'b1;
      repeat (16) @(negedge Clk);
      pix(10, 10);
      check("held_high_one_tick", is_life_icon, 0);
      frame_clk = 1'b0;
      @(negedge Clk);
      check("held_invuln", invuln, 1);
      #2 Reset = 1'b0;
      #1;
      check("async_invuln", invuln, 0);
      check("async_lives", lives, 3);
      check("async_icon", is_life_icon, 1);
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk);
      check("post_reset_game_over", game_over, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
